// File: rtl/updown_counter_param.sv
// Parametrised up/down event/timebase counter: prescaler, sync load, wrap/saturate, sticky flags.
// All outputs registered and updated on the step edge; load beats step, no backpressure.
module updown_counter_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 255,
  parameter int unsigned STEP     = 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sat_mode,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             tick,
  output logic             tc,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH:0] MAX_X    = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_X    = MAX_X + 1'b1;
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             step;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   load_x;
  logic             up_bnd;
  logic             dn_bnd;
  logic             bnd;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic [WIDTH-1:0] load_clamped;

  // Arithmetic is done one bit wider so MAX = 2^WIDTH-1 cannot alias on the up compare.
  assign cnt_x  = {1'b0, cnt_q};
  assign up_sum = cnt_x + STEP_X;
  assign up_bnd = up_sum > MAX_X;
  assign dn_bnd = cnt_x < STEP_X;
  assign load_x = {1'b0, load_value};
  assign bnd    = direction ? up_bnd : dn_bnd;
  assign step   = enable && !load && (pre_q == PRE_LAST);

  assign load_clamped = (load_x > MAX_X) ? MAX_W : load_value;

  always_comb begin
    up_next = up_sum[WIDTH-1:0];
    if (up_bnd) begin
      up_next = sat_mode ? MAX_W : WIDTH'(up_sum - MOD_X);
    end
  end

  always_comb begin
    dn_next = cnt_q - STEP_W;
    if (dn_bnd) begin
      dn_next = sat_mode ? '0 : WIDTH'(cnt_x + MOD_X - STEP_X);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (load) begin
      cnt_d = load_clamped;
      pre_d = '0;
    end else if (enable) begin
      if (step) begin
        pre_d  = '0;
        cnt_d  = direction ? up_next : dn_next;
        tick_d = 1'b1;
        tc_d   = bnd;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // A boundary event on the same edge as clear_flags leaves its flag set.
  always_comb begin
    ovf_d = ovf_q && !clear_flags;
    unf_d = unf_q && !clear_flags;
    if (step && direction && up_bnd) begin
      ovf_d = 1'b1;
    end
    if (step && !direction && dn_bnd) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign counter_out = cnt_q;
  assign tick        = tick_q;
  assign tc          = tc_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
